cu_req_responder: RTL and testbench
===================================

// Module: cu_req_responder
// PURPOSE
//  CU-side responder for the arbitrated CU request interface (ar2cu_* / cu2ar_*).
//  Accepts the single granted IFU/DFU write or read request into a NUM_REGS x AXI_WIDTH register bank.
//  Answers with ack, read data and busy. Launches the workload via cu2ar_start_wl on a CTRL write.
// PARAMETERS
//  AXI_WIDTH  64  data/address width
//  NUM_REGS   16  register count (power of 2, >=4); IDX_W = $clog2(NUM_REGS)
//  ADDR_LSB   3   byte-address LSBs dropped (8-byte registers)
//  READ_LAT   2   cycles from read accept to response, 1..4
// PORTS
//  clk                    in   1          clock
//  rst                    in   1          async reset, active-high
//  ar2cu_data_out         in   AXI_WIDTH  write data
//  ar2cu_data_out_valid   in   1          write data valid
//  ar2cu_addr             in   AXI_WIDTH  byte address
//  ar2cu_addr_valid       in   1          address valid
//  ar2cu_wr_rqst          in   1          write request
//  ar2cu_rd_rqst          in   1          read request
//  cu_wl_done             in   1          workload-complete pulse from compute core
//  cu2ar_start_wl         out  1          1-cycle workload start pulse
//  cu2ar_data_in          out  AXI_WIDTH  read data
//  cu2ar_data_in_valid    out  1          read data valid
//  cu2ar_busy             out  1          responder not in IDLE
//  cu2ar_ack              out  1          1-cycle completion pulse (reads and writes)
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset: all outputs 0, bank 0, running 0, FSM IDLE. Asserting rst mid-op aborts the op with no ack.
//  Decode: idx = addr[ADDR_LSB +: IDX_W].
//   - in-range iff addr[AXI_WIDTH-1:ADDR_LSB+IDX_W] == 0.
//   - addr[ADDR_LSB-1:0] ignored.
//  Map:
//   - idx0 CTRL: bit0 START, self-clearing, always reads 0; other bits stored.
//   - idx1 STATUS: read-only, {63'b0, running}.
//   - idx2..NUM_REGS-1: plain RW.
//  Requests are sampled only in IDLE. Inputs while busy are ignored (arbiter gates on busy).
//  FSM states: IDLE, WR_ACK, RD_WAIT, RD_RESP.
//   - IDLE, write accept (wr_rqst & addr_valid & data_out_valid): bank updated at that edge -> WR_ACK.
//   - IDLE, read accept (rd_rqst & addr_valid, no write accept): idx latched, cnt=READ_LAT-1.
//     Goes to RD_RESP if cnt==0, else RD_WAIT.
//   - Both wr and rd valid: write wins, read dropped.
//   - addr_valid with neither wr nor rd: ignored.
//   - WR_ACK: ack=1 for one cycle -> IDLE.
//   - RD_WAIT: cnt decrements; at 0 -> RD_RESP.
//   - RD_RESP: data_in_valid=1, ack=1, data_in=read value, one cycle -> IDLE.
//  Latency: write ack one cycle after accept. Read response READ_LAT cycles after accept.
//  Read value is sampled at the RD_RESP transition, not at accept.
//  busy=1 in every state except IDLE. data_in is 0 whenever data_in_valid=0.
//  Out of range: writes dropped, still acked; reads return 0, still acked.
//  STATUS write: dropped, acked.
//  START: CTRL write with data[0]=1 while running=0 gives:
//   - start_wl=1 in the WR_ACK cycle, coincident with ack.
//   - running set at the same edge.
//  START while running=1: no pulse, running unchanged, write still acked.
//  cu_wl_done clears running. If done and start hit the same edge, start wins (running stays 1).
//  Back-to-back: a new request is accepted on the first IDLE cycle after ack.
// TESTING
//  Write idx5 addr 0x28 data 0xA5A5 -> ack@+1, busy@+1 only. Read 0x28 -> data 0xA5A5, valid+ack @+READ_LAT.
//  Write CTRL data 0x1 -> start_wl and ack same cycle. STATUS read=1. Read CTRL=0. Pulse cu_wl_done -> STATUS=0.
//  Second START while running -> ack, no start_wl. Done+START same cycle -> STATUS stays 1.
//  Write addr 0x1000 (out of range) -> ack, bank unchanged. Read 0x1000 -> 0 with valid+ack.
//  wr_rqst & rd_rqst together at addr 0x18 -> write performed, single ack, no data_in_valid.
//  Assert rst during RD_WAIT -> all outputs 0 immediately, no ack. After release, next read works.

Source files
------------

// File: rtl/cu_req_responder_if.sv
// Arbiter <-> CU request bus: arbiter drives ar2cu_* requests, the CU answers on cu2ar_*.
// Pure wiring bundle; no latency, flow control is the busy/ack pair.
interface cu_req_responder_if #(
    parameter int AXI_WIDTH = 64
);
    logic [AXI_WIDTH-1:0] ar2cu_data_out;
    logic                 ar2cu_data_out_valid;
    logic [AXI_WIDTH-1:0] ar2cu_addr;
    logic                 ar2cu_addr_valid;
    logic                 ar2cu_wr_rqst;
    logic                 ar2cu_rd_rqst;
    logic                 cu2ar_start_wl;
    logic [AXI_WIDTH-1:0] cu2ar_data_in;
    logic                 cu2ar_data_in_valid;
    logic                 cu2ar_busy;
    logic                 cu2ar_ack;

    modport master (
        output ar2cu_data_out, ar2cu_data_out_valid, ar2cu_addr, ar2cu_addr_valid,
               ar2cu_wr_rqst, ar2cu_rd_rqst,
        input  cu2ar_start_wl, cu2ar_data_in, cu2ar_data_in_valid, cu2ar_busy, cu2ar_ack
    );

    modport slave (
        input  ar2cu_data_out, ar2cu_data_out_valid, ar2cu_addr, ar2cu_addr_valid,
               ar2cu_wr_rqst, ar2cu_rd_rqst,
        output cu2ar_start_wl, cu2ar_data_in, cu2ar_data_in_valid, cu2ar_busy, cu2ar_ack
    );
endinterface

// File: rtl/cu_req_responder.sv
// CU register-bank responder: accepts one granted write/read, acks it, launches the workload on CTRL.START.
// Write ack 1 cycle after accept, read response READ_LAT cycles after; busy holds off new requests until IDLE.
module cu_req_responder #(
    parameter int AXI_WIDTH = 64,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_LSB  = 3,
    parameter int READ_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cu_wl_done,
    cu_req_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_RESP} state_t;

    state_t               state, state_nxt;
    logic [AXI_WIDTH-1:0] bank [NUM_REGS];
    logic [IDX_W-1:0]     idx_q;
    logic                 rng_q;
    logic [CNT_W-1:0]     cnt;
    logic [AXI_WIDTH-1:0] rd_data;
    logic                 start_q;
    logic                 running;

    logic [IDX_W-1:0]     req_idx;
    logic                 in_range;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 start_req;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_rng;
    logic [AXI_WIDTH-1:0] rd_value;
    logic                 unused_addr_lsbs;

    assign req_idx          = bus.ar2cu_addr[ADDR_LSB +: IDX_W];
    assign in_range         = (bus.ar2cu_addr[AXI_WIDTH-1:ADDR_LSB+IDX_W] == '0);
    assign unused_addr_lsbs = ^bus.ar2cu_addr[ADDR_LSB-1:0];

    assign wr_acc = (state == IDLE) && bus.ar2cu_wr_rqst && bus.ar2cu_addr_valid
                    && bus.ar2cu_data_out_valid;
    assign rd_acc = (state == IDLE) && bus.ar2cu_rd_rqst && bus.ar2cu_addr_valid && !wr_acc;
    assign start_req = wr_acc && in_range && (req_idx == '0) && bus.ar2cu_data_out[0] && !running;

    // With READ_LAT==1 the response is captured on the accept edge, before idx_q is loaded.
    assign sel_idx = (state == IDLE) ? req_idx  : idx_q;
    assign sel_rng = (state == IDLE) ? in_range : rng_q;

    always_comb begin
        rd_value = '0;
        if (sel_rng) begin
            if (sel_idx == IDX_W'(1))
                rd_value = AXI_WIDTH'(running);
            else
                rd_value = bank[sel_idx];
        end
    end

    always_comb begin
        state_nxt               = state;
        bus.cu2ar_ack           = 1'b0;
        bus.cu2ar_data_in_valid = 1'b0;
        bus.cu2ar_data_in       = '0;
        bus.cu2ar_start_wl      = 1'b0;
        bus.cu2ar_busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (wr_acc)
                    state_nxt = WR_ACK;
                else if (rd_acc)
                    state_nxt = (READ_LAT == 1) ? RD_RESP : RD_WAIT;
            end
            WR_ACK: begin
                bus.cu2ar_ack      = 1'b1;
                bus.cu2ar_start_wl = start_q;
                state_nxt          = IDLE;
            end
            RD_WAIT: begin
                if (cnt == CNT_W'(1))
                    state_nxt = RD_RESP;
            end
            RD_RESP: begin
                bus.cu2ar_ack           = 1'b1;
                bus.cu2ar_data_in_valid = 1'b1;
                bus.cu2ar_data_in       = rd_data;
                state_nxt               = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx_q   <= '0;
            rng_q   <= 1'b0;
            cnt     <= '0;
            rd_data <= '0;
            start_q <= 1'b0;
            running <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                bank[i] <= '0;
        end else begin
            state <= state_nxt;
            if (wr_acc) begin
                start_q <= start_req;
                if (in_range) begin
                    // START is self-clearing, so bit0 of CTRL is never stored.
                    if (req_idx == '0)
                        bank[0] <= {bus.ar2cu_data_out[AXI_WIDTH-1:1], 1'b0};
                    else if (req_idx != IDX_W'(1))
                        bank[req_idx] <= bus.ar2cu_data_out;
                end
            end
            if (rd_acc) begin
                idx_q <= req_idx;
                rng_q <= in_range;
                cnt   <= CNT_W'(READ_LAT - 1);
            end
            if (state == RD_WAIT)
                cnt <= cnt - 1'b1;
            if (state_nxt == RD_RESP && state != RD_RESP)
                rd_data <= rd_value;
            if (start_req)
                running <= 1'b1;
            else if (cu_wl_done)
                running <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cu_req_responder.sv
// Directed bench for cu_req_responder: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_cu_req_responder;
    localparam int AW = 64;
    localparam int RL = 2;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        valid;
        logic        start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic cu_wl_done;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cu_req_responder_if #(.AXI_WIDTH(AW)) bus ();

    cu_req_responder #(
        .AXI_WIDTH(AW), .NUM_REGS(16), .ADDR_LSB(3), .READ_LAT(RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cu_wl_done (cu_wl_done),
        .bus        (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.cu2ar_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                check("resp_data", bus.cu2ar_data_in, e.data);
                check("resp_valid", 64'(bus.cu2ar_data_in_valid), 64'(e.valid));
                check("resp_start", 64'(bus.cu2ar_start_wl), 64'(e.start));
            end
        end else begin
            check("quiet_data", bus.cu2ar_data_in, 64'h0);
            check("quiet_flags", {62'b0, bus.cu2ar_data_in_valid, bus.cu2ar_start_wl}, 64'h0);
        end
    end

    task automatic clear_inputs();
        bus.ar2cu_wr_rqst        = 1'b0;
        bus.ar2cu_rd_rqst        = 1'b0;
        bus.ar2cu_addr_valid     = 1'b0;
        bus.ar2cu_data_out_valid = 1'b0;
        bus.ar2cu_addr           = '0;
        bus.ar2cu_data_out       = '0;
        cu_wl_done               = 1'b0;
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] exp_data,
                         input bit exp_valid, input bit exp_start, input bit done_too);
        exp_t e;
        bit   got = 1'b0;
        @(negedge clk);
        bus.ar2cu_wr_rqst        = wr;
        bus.ar2cu_rd_rqst        = rd;
        bus.ar2cu_addr_valid     = 1'b1;
        bus.ar2cu_data_out_valid = wr;
        bus.ar2cu_addr           = addr;
        bus.ar2cu_data_out       = data;
        cu_wl_done               = done_too;
        e.cyc   = cyc + ((rd && !wr) ? RL : 1);
        e.data  = exp_data;
        e.valid = exp_valid;
        e.start = exp_start;
        exp_q.push_back(e);
        @(posedge clk);
        #1 clear_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cu2ar_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=none expected=ack addr=%h", addr);
        end else begin
            check("busy_at_ack", 64'(bus.cu2ar_busy), 64'h1);
        end
    endtask

    task automatic wr_reg(input logic [63:0] addr, input logic [63:0] data, input bit exp_start);
        issue(1'b1, 1'b0, addr, data, 64'h0, 1'b0, exp_start, 1'b0);
    endtask

    task automatic rd_reg(input logic [63:0] addr, input logic [63:0] exp_data);
        issue(1'b0, 1'b1, addr, 64'h0, exp_data, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        cu_wl_done = 1'b1;
        @(negedge clk);
        cu_wl_done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"},   64'(bus.cu2ar_ack), 64'h0);
        check({tag, "_valid"}, 64'(bus.cu2ar_data_in_valid), 64'h0);
        check({tag, "_start"}, 64'(bus.cu2ar_start_wl), 64'h0);
        check({tag, "_busy"},  64'(bus.cu2ar_busy), 64'h0);
        check({tag, "_data"},  bus.cu2ar_data_in, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Basic RW, busy drops right after the ack cycle.
        wr_reg(64'h28, 64'hA5A5, 1'b0);
        @(negedge clk);
        check("busy_after_ack", 64'(bus.cu2ar_busy), 64'h0);
        rd_reg(64'h28, 64'hA5A5);

        // START / STATUS / done handshake.
        wr_reg(64'h0, 64'h1, 1'b1);
        rd_reg(64'h8, 64'h1);
        rd_reg(64'h0, 64'h0);
        pulse_done();
        rd_reg(64'h8, 64'h0);
        wr_reg(64'h0, 64'h1, 1'b1);
        rd_reg(64'h8, 64'h1);
        wr_reg(64'h0, 64'hF1, 1'b0);
        rd_reg(64'h8, 64'h1);
        rd_reg(64'h0, 64'hF0);
        pulse_done();
        rd_reg(64'h8, 64'h0);
        issue(1'b1, 1'b0, 64'h0, 64'h1, 64'h0, 1'b0, 1'b1, 1'b1);
        rd_reg(64'h8, 64'h1);
        wr_reg(64'h0, 64'hF0, 1'b0);

        // Out-of-range, ignored address LSBs, read-only STATUS.
        wr_reg(64'h1000, 64'hDEAD, 1'b0);
        rd_reg(64'h0, 64'hF0);
        rd_reg(64'h1000, 64'h0);
        wr_reg(64'h2D, 64'h1234, 1'b0);
        rd_reg(64'h28, 64'h1234);
        wr_reg(64'h8, 64'h0, 1'b0);
        rd_reg(64'h8, 64'h1);

        // Write and read together: write wins, single ack without data valid.
        issue(1'b1, 1'b1, 64'h18, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0);
        rd_reg(64'h18, 64'h77);

        // Address valid alone is ignored.
        @(negedge clk);
        bus.ar2cu_addr_valid = 1'b1;
        bus.ar2cu_addr       = 64'h18;
        @(posedge clk);
        #1 clear_inputs();
        repeat (4) @(negedge clk);
        check("addr_only_busy", 64'(bus.cu2ar_busy), 64'h0);

        // Reset during RD_WAIT aborts with no ack.
        @(negedge clk);
        bus.ar2cu_rd_rqst    = 1'b1;
        bus.ar2cu_addr_valid = 1'b1;
        bus.ar2cu_addr       = 64'h28;
        @(posedge clk);
        #1 clear_inputs();
        check("rd_wait_busy", 64'(bus.cu2ar_busy), 64'h1);
        #1 rst = 1'b1;
        #1 check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_reg(64'h8, 64'h0);
        rd_reg(64'h28, 64'h0);
        wr_reg(64'h30, 64'h55, 1'b0);
        rd_reg(64'h30, 64'h55);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
